rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Converts field-level instruction descriptions (format, opcode, funct3/funct7, register indices, signed immediate) into 32-bit RV64IM machine words.
- Packs encoded words in pairs into 64-bit words for writing to instruction memory over the 64-bit bus path.
- Acts as the inverse of the instruction decoder; used by the test-program loader and self-check benches to generate decoder stimulus.

Parameters:
- NOP_WORD, 32'h00000013, pad word (addi x0,x0,0) used to fill the high half on a flush.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  instruction descriptor valid
- in_ready  output  1  encoder can accept a descriptor this cycle
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=I-shift (6-bit shamt); 7=illegal
- in_opcode  input  7  opcode[6:0]
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7; bits[6:1] form funct6 for I-shift
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  32  signed immediate, byte offset for B/J, full value for U
- in_flush  input  1  emit any held half-word after this cycle's accept
- out_valid  output  1  packed word available
- out_ready  input  1  consumer accepts out_data
- out_data  output  64  packed word; first instruction in [31:0]
- out_mask  output  2  bit0 = low half real, bit1 = high half real
- err_pulse  output  1  one-cycle pulse: last descriptor rejected
- err_count  output  ERR_W  saturating count of rejected descriptors

Behaviour:
- Reset (reset==0 at posedge): state EMPTY; out_valid=0, out_data=0, out_mask=0, err_pulse=0, err_count=0. The held low half is discarded.
- in_ready = !out_valid || out_ready. An accept occurs when in_valid && in_ready.
- Encoding rules (combinational on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - I-shift: {funct7[6:1], imm[5:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range checks. A failing descriptor is an error:
  - I/S: -2048..2047.
  - B: -4096..4094, and imm[0]=0.
  - J: -1048576..1048574, and imm[0]=0.
  - U: imm[11:0]=0.
  - I-shift: 0..63.
  - fmt 7: always an error.
- Error handling: the descriptor is accepted and dropped. err_pulse=1 in the next cycle and err_count increments, saturating at all-ones. Packer state is unchanged; a flush on the same descriptor is still honoured.
- Packer states:
  - EMPTY + valid accept: word goes to lo, move to HALF. If in_flush is also set, emit {NOP_WORD, word} with mask 01 and stay EMPTY.
  - HALF + valid accept: emit {word, lo} with mask 11, move to EMPTY. in_flush is redundant here.
  - HALF + in_flush without a valid accept (requires in_ready): emit {NOP_WORD, lo} with mask 01, move to EMPTY.
  - EMPTY + flush only: no action.
- Emit means out_valid=1 with out_data/out_mask registered at the next posedge. Latency is 1 cycle from the completing accept.
- out_valid drops after a cycle with out_ready=1 unless a new emit happens in the same cycle (back-to-back output allowed).
- Backpressure: while out_valid && !out_ready, out_data and out_mask are held stable and in_ready=0.

Test Plan:
- addi x1,x0,5 (fmt1, op 0x13, imm 5), then add x3,x1,x2 (fmt0, op 0x33) -> one emit: out_data=64'h002081B3_00500093, mask 11.
- jal x1,8 with in_flush -> out_data=64'h00000013_008000EF, mask 01; beq x1,x2,-4 alone followed by a flush-only cycle -> low half 32'hFE208EE3, mask 01.
- addi imm=2048, then B imm=3 (odd), then fmt 7 -> three err_pulses, err_count=3, no out_valid; a following sw x2,8(x1) + lui x5,0x12345000 -> 64'h123452B7_0020A423.
- Hold out_ready=0 for 5 cycles after an emit -> out_data stable, in_ready=0, no descriptor lost; release -> next pair emits one cycle after its second accept.
- Assert reset while in HALF holding 0x00500093, then send add + flush -> output {NOP_WORD, 0x002081B3}, mask 01; the held word never appears.
- Force err_count to all-ones minus 1, send 3 bad descriptors -> count saturates at 16'hFFFF, each still pulses err_pulse.

Source files
------------

// File: rtl/rv_instr_encoder_if.sv
// Descriptor-in / packed-word-out stream bundle for rv_instr_encoder.
// Valid/ready: a transfer happens on a posedge where valid && ready are both 1; a source holds valid and its payload stable until then.
interface rv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_mask;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Encodes RV64IM field descriptors into 32-bit words and packs them in pairs
// into 64-bit instruction-memory words; out-of-range descriptors are counted and dropped.
module rv_instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  parameter int          ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  rv_instr_encoder_if.slave bus,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             dbg_state
);

  typedef enum logic {S_EMPTY = 1'b0, S_HALF = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [31:0]  lo_q, lo_d;
  logic [31:0]  word;
  logic         bad;
  logic         accept, good;
  logic         emit;
  logic [63:0]  emit_data;
  logic [1:0]   emit_mask;
  logic signed [31:0] imm_s;

  assign imm_s        = bus.in_imm;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign good         = accept && !bad;
  assign dbg_state    = state_q;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (bus.in_fmt)
      3'd0: word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: begin
        word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        bad  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      3'd2: begin
        word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
        bad  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      3'd3: begin
        word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        bad  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      end
      3'd4: begin
        word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        bad  = |bus.in_imm[11:0];
      end
      3'd5: begin
        word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        bad  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.in_imm[0];
      end
      3'd6: begin
        word = {bus.in_funct7[6:1], bus.in_imm[5:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        bad  = bus.in_imm > 32'd63;
      end
      default: bad = 1'b1;
    endcase
  end

  // A rejected descriptor still counts as a flush request, so a held half can drain.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_mask = 2'b00;
    case (state_q)
      S_EMPTY: begin
        if (good) begin
          if (bus.in_flush) begin
            emit      = 1'b1;
            emit_data = {NOP_WORD, word};
            emit_mask = 2'b01;
          end else begin
            lo_d    = word;
            state_d = S_HALF;
          end
        end
      end
      S_HALF: begin
        if (good) begin
          emit      = 1'b1;
          emit_data = {word, lo_q};
          emit_mask = 2'b11;
          state_d   = S_EMPTY;
        end else if (bus.in_flush && bus.in_ready) begin
          emit      = 1'b1;
          emit_data = {NOP_WORD, lo_q};
          emit_mask = 2'b01;
          state_d   = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_EMPTY;
      lo_q          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_mask  <= 2'b00;
      err_pulse     <= 1'b0;
      err_count     <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= emit_data;
        bus.out_mask  <= emit_mask;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      err_pulse <= accept && bad;
      if (accept && bad && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed-vector bench for rv_instr_encoder: encode table plus backpressure,
// reset-while-half and error-counter saturation sequences.
module tb_rv_instr_encoder;

  logic        clk;
  logic        reset;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        dbg_state;
  int          n_cmp;
  int          n_err;

  rv_instr_encoder_if bus ();

  rv_instr_encoder #(.NOP_WORD(32'h00000013), .ERR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        fl;
    logic        e_emit;
    logic [63:0] e_data;
    logic [1:0]  e_mask;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] fmt, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic fl, logic e_emit, logic [63:0] e_data,
                              logic [1:0] e_mask, logic e_err, logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.fl = fl;
    r.e_emit = e_emit; r.e_data = e_data; r.e_mask = e_mask;
    r.e_err = e_err; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_flush  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_opcode = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
  endtask

  task automatic set_desc(input vec_t r);
    bus.in_valid  = r.v;
    bus.in_fmt    = r.fmt;
    bus.in_opcode = r.op;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_imm    = r.imm;
    bus.in_flush  = r.fl;
  endtask

  // Called at a negedge; drives one cycle, checks registered outputs at the next negedge.
  task automatic apply(input string name, input vec_t r);
    set_desc(r);
    @(negedge clk);
    check({name, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, r.e_emit});
    if (r.e_emit) begin
      check({name, ".out_data"}, bus.out_data, r.e_data);
      check({name, ".out_mask"}, {62'd0, bus.out_mask}, {62'd0, r.e_mask});
    end
    check({name, ".err_pulse"}, {63'd0, err_pulse}, {63'd0, r.e_err});
    check({name, ".err_count"}, {48'd0, err_count}, {48'd0, r.e_cnt});
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [63:0] PAIR_ADDI_ADD = 64'h002081B3_00500093;

  vec_t addi5, add3, sw8, lui5;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle_inputs();

    addi5 = mk(1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 64'd0, 2'b00, 0, 16'd0);
    add3  = mk(1, 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, PAIR_ADDI_ADD, 2'b11, 0, 16'd0);
    sw8   = mk(1, 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 0, 0, 64'd0, 2'b00, 0, 16'd0);
    lui5  = mk(1, 3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 1,
               64'h123452B7_0020A423, 2'b11, 0, 16'd0);

    // v fmt op f3 f7 rd rs1 rs2 imm fl | emit data mask err cnt
    tbl.push_back(addi5);
    tbl.push_back(add3);
    tbl.push_back(mk(1, 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1, 1, 64'h00000013_008000EF, 2'b01, 0, 16'd0));
    tbl.push_back(mk(1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 0, 0, 64'd0, 2'b00, 0, 16'd0));
    tbl.push_back(mk(0, 3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1, 64'h00000013_FE208EE3, 2'b01, 0, 16'd0));
    tbl.push_back(mk(1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 64'd0, 2'b00, 1, 16'd1));
    tbl.push_back(mk(1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 0, 0, 64'd0, 2'b00, 1, 16'd2));
    tbl.push_back(mk(1, 3'd7, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 64'd0, 2'b00, 1, 16'd3));
    sw8.e_cnt = 16'd3;  lui5.e_cnt = 16'd3;
    tbl.push_back(sw8);
    tbl.push_back(lui5);
    tbl.push_back(mk(1, 3'd6, 7'h13, 3'd1, 7'h00, 5'd2, 5'd2, 5'd0, 32'd64, 0, 0, 64'd0, 2'b00, 1, 16'd4));
    tbl.push_back(mk(1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096, 0, 0, 64'd0, 2'b00, 1, 16'd5));
    tbl.push_back(mk(1, 3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 0, 64'd0, 2'b00, 1, 16'd6));
    tbl.push_back(mk(1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFFF800, 0, 0, 64'd0, 2'b00, 0, 16'd6));
    tbl.push_back(mk(1, 3'd6, 7'h13, 3'd5, 7'h20, 5'd2, 5'd2, 5'd0, 32'd63, 0, 1, 64'h43F15113_80008093, 2'b11, 0, 16'd6));
    tbl.push_back(mk(1, 3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1, 1, 64'h00000013_8000006F, 2'b01, 0, 16'd6));
    tbl.push_back(mk(0, 3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 64'd0, 2'b00, 0, 16'd6));
    tbl.push_back(mk(1, 3'd3, 7'h63, 3'd1, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094, 1, 1, 64'h00000013_7E001FE3, 2'b01, 0, 16'd6));
    tbl.push_back(mk(1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 64'd0, 2'b00, 0, 16'd6));
    tbl.push_back(mk(1, 3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1, 64'h00000013_00500093, 2'b01, 1, 16'd7));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst.out_data", bus.out_data, 64'd0);
    check("rst.out_mask", {62'd0, bus.out_mask}, 64'd0);
    check("rst.err_pulse", {63'd0, err_pulse}, 64'd0);
    check("rst.err_count", {48'd0, err_count}, 64'd0);
    check("rst.state", {63'd0, dbg_state}, 64'd0);
    check("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: output held, input stalled, stalled descriptor not lost
    do_reset();
    bus.out_ready = 1'b0;
    addi5.e_cnt = 16'd0;
    apply("bp.addi", addi5);
    apply("bp.add", add3);
    set_desc(sw8);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp.hold%0d.in_ready", k), {63'd0, bus.in_ready}, 64'd0);
      check($sformatf("bp.hold%0d.out_valid", k), {63'd0, bus.out_valid}, 64'd1);
      check($sformatf("bp.hold%0d.out_data", k), bus.out_data, PAIR_ADDI_ADD);
      check($sformatf("bp.hold%0d.out_mask", k), {62'd0, bus.out_mask}, 64'd3);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    sw8.e_cnt = 16'd0;
    apply("bp.sw_release", sw8);
    lui5.e_cnt = 16'd0;
    apply("bp.lui", lui5);

    // Reset while HALF discards the held low word
    apply("rh.addi", addi5);
    check("rh.state_half", {63'd0, dbg_state}, 64'd1);
    do_reset();
    check("rh.state_empty", {63'd0, dbg_state}, 64'd0);
    add3.fl = 1'b1;
    add3.e_data = 64'h00000013_002081B3;
    add3.e_mask = 2'b01;
    apply("rh.add_flush", add3);

    // Error counter saturation
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_fmt   = 3'd7;
    repeat (65534) @(negedge clk);
    check("sat.pre_count", {48'd0, err_count}, 64'h0000_0000_0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sat%0d.err_pulse", k), {63'd0, err_pulse}, 64'd1);
      check($sformatf("sat%0d.err_count", k), {48'd0, err_count}, 64'h0000_0000_0000_FFFF);
      check($sformatf("sat%0d.out_valid", k), {63'd0, bus.out_valid}, 64'd0);
    end
    idle_inputs();
    @(negedge clk);
    check("sat.pulse_clear", {63'd0, err_pulse}, 64'd0);
    check("sat.count_hold", {48'd0, err_count}, 64'h0000_0000_0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
